// File: rtl/mode_counter.sv
// Multi-mode counter: binary up/down, Gray and Johnson sequences.
// Programmable modulo, enable, synchronous load and terminal-count flag.
module mode_counter #(
   parameter int WIDTH = 4,
   parameter int MAX   = 2**WIDTH-1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             tc
);

   localparam logic [1:0] M_UP = 2'b00;
   localparam logic [1:0] M_DN = 2'b01;
   localparam logic [1:0] M_GR = 2'b10;
   localparam logic [1:0] M_JN = 2'b11;

   localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] LP_JTC  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_out;
   logic [1:0]       r_mode_q;
   logic             r_init;

   logic [1:0]       w_mode_q;
   logic [WIDTH-1:0] w_adv;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic [WIDTH-1:0] w_out_nxt;
   logic             w_term;

   // The mode seen during reset counts as already registered, so the first
   // edge after reset release does not look like a mode switch.
   assign w_mode_q = r_init ? mode : r_mode_q;

   // Terminal-state detection for the mode currently in effect.
   always_comb begin
      w_term = 1'b0;
      unique case (w_mode_q)
         M_DN:    w_term = (r_cnt == '0);
         M_JN:    w_term = (r_cnt == LP_JTC);
         default: w_term = (r_cnt >= LP_MAX);
      endcase
   end

   assign tc = en & w_term;

   // One-step advance; Gray advances the binary count and encodes on output.
   always_comb begin
      w_adv = r_cnt;
      unique case (w_mode_q)
         M_DN:    w_adv = (r_cnt == '0) ? LP_MAX : r_cnt - LP_ONE;
         M_JN:    w_adv = {r_cnt[WIDTH-2:0], ~r_cnt[WIDTH-1]};
         default: w_adv = (r_cnt >= LP_MAX) ? '0 : r_cnt + LP_ONE;
      endcase
   end

   // Next count: load beats a mode switch, which beats counting.
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (load) begin
         w_cnt_nxt = (mode == M_JN) ? '0 : load_val;
      end else if (mode != w_mode_q) begin
         w_cnt_nxt = '0;
      end else if (en) begin
         w_cnt_nxt = w_adv;
      end
   end

   // Output encoding from the next-state count, so out has no extra latency.
   always_comb begin
      w_out_nxt = w_cnt_nxt;
      if (mode == M_GR) begin
         w_out_nxt = w_cnt_nxt ^ (w_cnt_nxt >> 1);
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_out    <= '0;
         r_mode_q <= M_UP;
         r_init   <= 1'b1;
      end else begin
         r_cnt    <= w_cnt_nxt;
         r_out    <= w_out_nxt;
         r_mode_q <= mode;
         r_init   <= 1'b0;
      end
   end

   assign out = r_out;

endmodule

// File: tb/tb_mode_counter.sv
// Bench for mode_counter (WIDTH=4, MAX=9): directed scenarios plus
// random stimulus checked against a sequence-level reference model.
module tb_mode_counter;

   localparam int W   = 4;
   localparam int MX  = 9;
   localparam int JP  = 2 * W;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic [1:0]   mode;
   logic         load;
   logic [W-1:0] load_val;
   logic [W-1:0] out;
   logic         tc;

   int n_chk = 0;
   int n_err = 0;

   // Reference state: binary value for bin/Gray, position index for Johnson.
   int m_cnt;
   int m_j;
   int m_mq;

   mode_counter #(.WIDTH(W), .MAX(MX)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mode     (mode),
      .load     (load),
      .load_val (load_val),
      .out      (out),
      .tc       (tc)
   );

   always #5 clk = ~clk;

   function automatic int jpat(int k);
      int mask;
      mask = (1 << W) - 1;
      if (k <= W) return (1 << k) - 1;
      return (mask << (k - W)) & mask;
   endfunction

   function automatic logic [W-1:0] f_out();
      int v;
      if (m_mq == 3)      v = jpat(m_j);
      else if (m_mq == 2) v = m_cnt ^ (m_cnt >> 1);
      else                v = m_cnt;
      return W'(v);
   endfunction

   function automatic logic f_tc(logic e);
      logic t;
      if (m_mq == 3)      t = (m_j == JP - 1);
      else if (m_mq == 1) t = (m_cnt == 0);
      else                t = (m_cnt >= MX);
      return e & t;
   endfunction

   task automatic m_step(logic e, int md, logic ld, int lv);
      if (ld) begin
         m_cnt = (md == 3) ? 0 : lv;
         m_j   = 0;
      end else if (md != m_mq) begin
         m_cnt = 0;
         m_j   = 0;
      end else if (e) begin
         case (md)
            1:       m_cnt = (m_cnt == 0) ? MX : m_cnt - 1;
            3:       m_j   = (m_j + 1) % JP;
            default: m_cnt = (m_cnt >= MX) ? 0 : m_cnt + 1;
         endcase
      end
      m_mq = md;
   endtask

   // Called at a negedge; drives inputs, lets one posedge pass, ends at negedge.
   task automatic do_cycle(logic e, int md, logic ld, int lv);
      en       = e;
      mode     = 2'(md);
      load     = ld;
      load_val = W'(lv);
      @(posedge clk);
      m_step(e, md, ld, lv);
      @(negedge clk);
   endtask

   // Called at a negedge; holds reset over one posedge, releases at negedge.
   task automatic do_reset(int md, logic e);
      rst  = 1'b1;
      mode = 2'(md);
      en   = e;
      load = 1'b0;
      m_cnt = 0;
      m_j   = 0;
      m_mq  = md;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      mode = 2'b01;
      en   = 1'b1;
      load = 1'b0;
      #1;
      n_chk++;
      if (out !== 4'h0) begin
         n_err++;
         $display("FAIL reset_out got %h want 0", out);
      end
      n_chk++;
      if (tc !== 1'b1) begin
         n_err++;
         $display("FAIL reset_tc_down got %b want 1", tc);
      end
      mode = 2'b00;
      #1;
      n_chk++;
      if (tc !== 1'b0) begin
         n_err++;
         $display("FAIL reset_tc_up got %b want 0", tc);
      end
   endtask

   task automatic test_bin_up();
      int exp_seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      do_reset(0, 1'b1);
      for (int i = 0; i < 12; i++) begin
         do_cycle(1'b1, 0, 1'b0, 0);
         n_chk++;
         if (out !== W'(exp_seq[i])) begin
            n_err++;
            $display("FAIL up_out step %0d got %h want %h", i, out, exp_seq[i]);
         end
         n_chk++;
         if (tc !== (exp_seq[i] == 9)) begin
            n_err++;
            $display("FAIL up_tc step %0d got %b want %b", i, tc, exp_seq[i] == 9);
         end
      end
   endtask

   task automatic test_bin_down();
      do_reset(1, 1'b1);
      n_chk++;
      if (tc !== 1'b1) begin
         n_err++;
         $display("FAIL down_tc_first got %b want 1", tc);
      end
      for (int i = 0; i < 11; i++) begin
         do_cycle(1'b1, 1, 1'b0, 0);
         n_chk++;
         if (out !== f_out() || tc !== f_tc(1'b1)) begin
            n_err++;
            $display("FAIL down step %0d got %h/%b want %h/%b",
                     i, out, tc, f_out(), f_tc(1'b1));
         end
      end
   endtask

   task automatic test_gray();
      logic [W-1:0] prev;
      do_reset(2, 1'b1);
      prev = out;
      for (int i = 0; i < 11; i++) begin
         do_cycle(1'b1, 2, 1'b0, 0);
         n_chk++;
         if (out !== f_out() || tc !== f_tc(1'b1)) begin
            n_err++;
            $display("FAIL gray step %0d got %h/%b want %h/%b",
                     i, out, tc, f_out(), f_tc(1'b1));
         end
         if (m_cnt != 0) begin
            n_chk++;
            if ($countones(out ^ prev) != 1) begin
               n_err++;
               $display("FAIL gray_onebit step %0d got %h after %h want 1 bit",
                        i, out, prev);
            end
         end
         prev = out;
      end
   endtask

   task automatic test_johnson();
      do_reset(3, 1'b1);
      for (int i = 0; i < 9; i++) begin
         do_cycle(1'b1, 3, 1'b0, 0);
         n_chk++;
         if (out !== f_out() || tc !== f_tc(1'b1)) begin
            n_err++;
            $display("FAIL john step %0d got %h/%b want %h/%b",
                     i, out, tc, f_out(), f_tc(1'b1));
         end
      end
      do_cycle(1'b1, 0, 1'b0, 0);
      n_chk++;
      if (out !== 4'h0) begin
         n_err++;
         $display("FAIL john_switch got %h want 0", out);
      end
   endtask

   task automatic test_load();
      do_reset(0, 1'b1);
      do_cycle(1'b1, 0, 1'b0, 0);
      do_cycle(1'b1, 0, 1'b1, 12);
      n_chk++;
      if (out !== 4'hC || tc !== 1'b1) begin
         n_err++;
         $display("FAIL load_oor got %h/%b want c/1", out, tc);
      end
      do_cycle(1'b1, 0, 1'b0, 0);
      n_chk++;
      if (out !== 4'h0) begin
         n_err++;
         $display("FAIL load_wrap got %h want 0", out);
      end
      do_cycle(1'b1, 1, 1'b1, 5);
      do_cycle(1'b1, 1, 1'b0, 0);
      n_chk++;
      if (out !== 4'h4) begin
         n_err++;
         $display("FAIL load_modechg got %h want 4", out);
      end
      do_cycle(1'b1, 3, 1'b1, 7);
      n_chk++;
      if (out !== 4'h0) begin
         n_err++;
         $display("FAIL load_john got %h want 0", out);
      end
   endtask

   task automatic test_hold_async();
      logic [W-1:0] held;
      do_reset(0, 1'b1);
      for (int i = 0; i < 5; i++) do_cycle(1'b1, 0, 1'b0, 0);
      held = out;
      for (int i = 0; i < 5; i++) begin
         do_cycle(1'b0, 0, 1'b0, 0);
         n_chk++;
         if (out !== held || out !== f_out() || tc !== 1'b0) begin
            n_err++;
            $display("FAIL hold step %0d got %h/%b want %h/0", i, out, tc, f_out());
         end
      end
      en = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      n_chk++;
      if (out !== 4'h0) begin
         n_err++;
         $display("FAIL async_rst got %h want 0", out);
      end
      m_cnt = 0;
      m_j   = 0;
      m_mq  = 0;
      @(negedge clk);
      rst = 1'b0;
      do_cycle(1'b1, 0, 1'b0, 0);
      n_chk++;
      if (out !== 4'h1) begin
         n_err++;
         $display("FAIL async_first got %h want 1", out);
      end
   endtask

   task automatic test_random();
      int md;
      logic e;
      logic ld;
      int lv;
      bit just_reset;
      md = 0;
      just_reset = 1'b0;
      for (int i = 0; i < 400; i++) begin
         e  = ($urandom_range(0, 3) != 0);
         ld = ($urandom_range(0, 7) == 0);
         lv = $urandom_range(0, 15);
         if (!just_reset && $urandom_range(0, 9) == 0) md = $urandom_range(0, 3);
         if ($urandom_range(0, 49) == 0) begin
            do_reset(md, e);
            just_reset = 1'b1;
         end else begin
            do_cycle(e, md, ld, lv);
            just_reset = 1'b0;
         end
         n_chk++;
         if (out !== f_out() || tc !== f_tc(en)) begin
            n_err++;
            $display("FAIL rand step %0d md %0d got %h/%b want %h/%b",
                     i, md, out, tc, f_out(), f_tc(en));
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      en       = 1'b0;
      mode     = 2'b00;
      load     = 1'b0;
      load_val = '0;
      m_cnt    = 0;
      m_j      = 0;
      m_mq     = 0;
      @(negedge clk);
      test_reset();
      @(negedge clk);
      test_bin_up();
      test_bin_down();
      test_gray();
      test_johnson();
      test_load();
      test_hold_async();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
